// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding imem request FSM and IF/ID pipeline register.
// Zero-wait memory sustains one instruction per cycle; a stalled or redirected fetch is buffered or dropped.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCWr,
  input  logic        IFIDwr,
  input  logic        rstIFID,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IFID_PC,
  output logic [31:0] IFID_Instr,
  output logic        IFID_valid
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_hold;
  logic [31:0] w_hold_nxt;
  logic [31:0] r_ifid_pc;
  logic [31:0] r_ifid_instr;
  logic        r_ifid_valid;
  logic [31:0] w_ifid_pc_nxt;
  logic [31:0] w_ifid_instr_nxt;
  logic        w_ifid_valid_nxt;
  logic [31:0] w_pc_plus4;
  logic        w_avail;
  logic [31:0] w_data;
  logic        w_consume;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_avail    = ((r_state == FETCH) && imem_ack) || (r_state == HOLD);
  assign w_data     = (r_state == HOLD) ? r_hold : imem_rdata;
  assign w_consume  = w_avail && PCWr && IFIDwr && !rstIFID && !redirect;

  assign imem_req   = rst_n && ((r_state == FETCH) || (r_state == DROP));
  assign imem_addr  = r_pc;
  assign IFID_PC    = r_ifid_pc;
  assign IFID_Instr = r_ifid_instr;
  assign IFID_valid = r_ifid_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_hold_nxt  = r_hold;
    if (redirect) begin
      w_pc_nxt = redirect_pc;
      // A request still in flight must have its response swallowed before refetching.
      if ((r_state == FETCH && !imem_ack) || r_state == DROP) begin
        w_state_nxt = DROP;
      end else begin
        w_state_nxt = FETCH;
      end
    end else if (w_consume) begin
      w_pc_nxt    = w_pc_plus4;
      w_state_nxt = FETCH;
    end else begin
      case (r_state)
        FETCH: begin
          if (imem_ack) begin
            w_hold_nxt  = imem_rdata;
            w_state_nxt = HOLD;
          end
        end
        DROP: begin
          if (imem_ack) begin
            w_state_nxt = FETCH;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_ifid_pc_nxt    = r_ifid_pc;
    w_ifid_instr_nxt = r_ifid_instr;
    w_ifid_valid_nxt = r_ifid_valid;
    if (rstIFID) begin
      w_ifid_pc_nxt    = 32'h0;
      w_ifid_instr_nxt = 32'h0;
      w_ifid_valid_nxt = 1'b0;
    end else if (IFIDwr) begin
      if (w_consume) begin
        w_ifid_pc_nxt    = w_pc_plus4;
        w_ifid_instr_nxt = w_data;
        w_ifid_valid_nxt = 1'b1;
      end else begin
        w_ifid_pc_nxt    = 32'h0;
        w_ifid_instr_nxt = 32'h0;
        w_ifid_valid_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_hold       <= 32'h0;
      r_ifid_pc    <= 32'h0;
      r_ifid_instr <= 32'h0;
      r_ifid_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_hold       <= w_hold_nxt;
      r_ifid_pc    <= w_ifid_pc_nxt;
      r_ifid_instr <= w_ifid_instr_nxt;
      r_ifid_valid <= w_ifid_valid_nxt;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; IF/ID loads are checked against a queue of expected {PC+4, instr}.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PCWr, IFIDwr, rstIFID, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] IFID_PC, IFID_Instr;
  logic        IFID_valid;

  logic        zw;
  logic        man_ack;
  logic [31:0] man_rdata;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  assign imem_ack   = zw ? imem_req : man_ack;
  assign imem_rdata = zw ? word_at(imem_addr) : man_rdata;

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .PCWr(PCWr), .IFIDwr(IFIDwr), .rstIFID(rstIFID),
    .redirect(redirect), .redirect_pc(redirect_pc), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .IFID_PC(IFID_PC), .IFID_Instr(IFID_Instr), .IFID_valid(IFID_valid)
  );

  logic        prev_valid = 1'b0;
  logic [31:0] prev_pc = 32'h0;
  logic [31:0] prev_instr = 32'h0;

  // A new IF/ID load is recognised by valid rising or the held pair changing.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && IFID_valid === 1'b1 &&
        !(prev_valid && prev_pc == IFID_PC && prev_instr == IFID_Instr)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ifid_unexpected got pc=%h instr=%h, required no load", IFID_PC, IFID_Instr);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({IFID_PC, IFID_Instr} !== e) begin
          errors++;
          $display("FAIL ifid_load got pc=%h instr=%h, required pc=%h instr=%h",
                   IFID_PC, IFID_Instr, e[63:32], e[31:0]);
        end
      end
    end
    prev_valid = IFID_valid;
    prev_pc    = IFID_PC;
    prev_instr = IFID_Instr;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h, required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic chk_ifid_zero(input string tag);
    chk({tag, "_valid"}, {31'h0, IFID_valid}, 32'h0);
    chk({tag, "_pc"}, IFID_PC, 32'h0);
    chk({tag, "_instr"}, IFID_Instr, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; PCWr = 1'b1; IFIDwr = 1'b1; rstIFID = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; zw = 1'b1; man_ack = 1'b0; man_rdata = 32'h0;

    // Reset, then zero-wait streaming
    step(); step();
    at_neg();
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk_ifid_zero("rst");
    exp_q.push_back({32'd4,  32'hA500_0000});
    exp_q.push_back({32'd8,  32'hA500_0004});
    exp_q.push_back({32'd12, 32'hA500_0008});
    exp_q.push_back({32'd16, 32'hA500_000C});
    step();
    rst_n = 1'b1;
    at_neg();
    chk("rel_req", {31'h0, imem_req}, 32'h1);
    chk("rel_addr", imem_addr, 32'h0);
    repeat (4) step();

    // Ack at 16 together with redirect and flush
    zw = 1'b0; man_ack = 1'b1; man_rdata = 32'hA500_0010;
    redirect = 1'b1; redirect_pc = 32'h100; rstIFID = 1'b1;
    step();
    redirect = 1'b0; rstIFID = 1'b0; man_ack = 1'b0;
    at_neg();
    chk_ifid_zero("flush");
    chk("flush_addr", imem_addr, 32'h100);
    chk("flush_req", {31'h0, imem_req}, 32'h1);

    // Reset during an outstanding request with an ack in the same cycle
    @(posedge clk); #1;
    rst_n = 1'b0; man_ack = 1'b1; man_rdata = 32'hA500_0100;
    step();
    man_ack = 1'b0;
    at_neg();
    chk("rst2_req", {31'h0, imem_req}, 32'h0);
    chk_ifid_zero("rst2");
    exp_q.push_back({32'd4, 32'hA500_0000});
    exp_q.push_back({32'd8, 32'hA500_0004});
    step();
    rst_n = 1'b1; zw = 1'b1;
    at_neg();
    chk("rel2_req", {31'h0, imem_req}, 32'h1);
    chk("rel2_addr", imem_addr, 32'h0);
    step(); step();

    // Stall with data returning at 8
    zw = 1'b0; man_ack = 1'b1; man_rdata = 32'hA500_0008; PCWr = 1'b0; IFIDwr = 1'b0;
    at_neg();
    chk("stall_addr", imem_addr, 32'h8);
    step();
    man_ack = 1'b0;
    at_neg();
    chk("hold1_req", {31'h0, imem_req}, 32'h0);
    chk("hold1_pc", IFID_PC, 32'h8);
    chk("hold1_instr", IFID_Instr, 32'hA500_0004);
    step();
    at_neg();
    chk("hold2_req", {31'h0, imem_req}, 32'h0);
    chk("hold2_pc", IFID_PC, 32'h8);
    chk("hold2_valid", {31'h0, IFID_valid}, 32'h1);
    exp_q.push_back({32'd12, 32'hA500_0008});
    PCWr = 1'b1; IFIDwr = 1'b1;
    step();
    at_neg();
    chk("unstall_addr", imem_addr, 32'hC);
    chk("unstall_req", {31'h0, imem_req}, 32'h1);

    // Ack and redirect together never load IF/ID
    man_ack = 1'b1; man_rdata = 32'hA500_000C; redirect = 1'b1; redirect_pc = 32'h4;
    step();
    man_ack = 1'b0; redirect = 1'b0;
    at_neg();
    chk("redir_ack_valid", {31'h0, IFID_valid}, 32'h0);
    chk("redir_ack_addr", imem_addr, 32'h4);
    step();
    at_neg();
    chk("pend_req", {31'h0, imem_req}, 32'h1);
    chk("pend_addr", imem_addr, 32'h4);

    // Redirect to 0x40 before the ack for 4 arrives
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    at_neg();
    chk("drop_req", {31'h0, imem_req}, 32'h1);
    chk("drop_addr", imem_addr, 32'h40);
    man_ack = 1'b1; man_rdata = 32'hA500_0004;
    step();
    at_neg();
    chk("drop_discard_valid", {31'h0, IFID_valid}, 32'h0);
    chk("drop_refetch_addr", imem_addr, 32'h40);
    exp_q.push_back({32'h44, 32'hA500_0040});
    man_rdata = 32'hA500_0040;
    step();
    man_ack = 1'b0;
    at_neg();
    chk("after_drop_addr", imem_addr, 32'h44);

    // PC wrap at the top of the address space
    man_ack = 1'b1; man_rdata = 32'hA500_0044; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0; man_rdata = 32'hA5FF_FFFC;
    exp_q.push_back({32'h0, 32'hA5FF_FFFC});
    at_neg();
    chk("wrap_addr_pre", imem_addr, 32'hFFFF_FFFC);
    step();
    man_ack = 1'b0;
    at_neg();
    chk("wrap_next_addr", imem_addr, 32'h0);
    chk("wrap_ifid_pc", IFID_PC, 32'h0);

    step(); step();
    at_neg();
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
